frame_sender: RTL



---
 rtl/frame_sender_if.sv | 83 ++++++++
 rtl/frame_sender.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sender_if.sv
// -----------------------------------------------------------------------------
// frame_sender_if
//   Signal bundle between frame_sender and its surroundings: the start/busy/
//   done handshake, the asynchronous-read pixel buffer bus and the serial link
//   toward the LED driver.
//
//   Optional macro FRAME_SENDER_CS_EN adds the active-low chip select cs_n.
//
//   Signals
//     start  request one frame (driven by the host side)
//     addr   pixel read address (driven by the sender)
//     pix    pixel data, combinational read of buffer[addr] (driven by buffer)
//     sck    serial clock, idle low
//     sdi    serial data, LSB of each pixel first
//     busy   frame in progress
//     done   one-cycle end-of-frame pulse
//     cs_n   chip select, low for the data-carrying part of the frame (macro)
//
//   Modports
//     master  the sender side (frame_sender)
//     slave   the host / buffer / receiver side
// -----------------------------------------------------------------------------
interface frame_sender_if #(
  parameter int CDEPTH      = 4,
  parameter int FRAME_ORDER = 10
);

  logic                   start;
  logic [FRAME_ORDER-1:0] addr;
  logic [3*CDEPTH-1:0]    pix;
  logic                   sck;
  logic                   sdi;
  logic                   busy;
  logic                   done;
`ifdef FRAME_SENDER_CS_EN
  logic                   cs_n;
`endif

`ifdef FRAME_SENDER_CS_EN
  modport master (
    input  start,
    input  pix,
    output addr,
    output sck,
    output sdi,
    output busy,
    output done,
    output cs_n
  );

  modport slave (
    output start,
    output pix,
    input  addr,
    input  sck,
    input  sdi,
    input  busy,
    input  done,
    input  cs_n
  );
`else
  modport master (
    input  start,
    input  pix,
    output addr,
    output sck,
    output sdi,
    output busy,
    output done
  );

  modport slave (
    output start,
    output pix,
    input  addr,
    input  sck,
    input  sdi,
    input  busy,
    input  done
  );
`endif

endinterface

// File: rtl/frame_sender.sv
// -----------------------------------------------------------------------------
// frame_sender
//   SPI-style transmitter that streams one full frame out of a pixel buffer to
//   the LED driver's serial frame input. Pixels are read in address order
//   0 .. 2**FRAME_ORDER-1 over an asynchronous-read bus and each pixel is
//   shifted out LSB first. sdi is set up while sck is low and held for the
//   whole high phase, so the receiver can sample on the rising edge.
//
//   After the last bit the link idles for GAP_CYCLES clocks so the receiver
//   can finish copying the frame, then done pulses for one cycle.
//
//   Optional macro FRAME_SENDER_CS_EN: adds active-low cs_n, low from the
//   first LOAD of the frame through the last high phase, high otherwise.
//
//   Parameters
//     CDEPTH        bits per colour channel (pixel = 3*CDEPTH bits)
//     FRAME_ORDER   frame holds 2**FRAME_ORDER pixels
//     SCK_DIV_BITS  each sck half-period lasts 2**SCK_DIV_BITS clk cycles
//     GAP_CYCLES    idle cycles between the last bit and done (>= 1)
//
//   Ports
//     clk    board clock
//     reset  asynchronous, active-high reset; aborts any frame in flight
//     bus    frame_sender_if.master: start, pix in; addr, sck, sdi, busy,
//            done (and cs_n with the macro) out, all outputs registered
// -----------------------------------------------------------------------------
module frame_sender #(
  parameter int CDEPTH       = 4,
  parameter int FRAME_ORDER  = 10,
  parameter int SCK_DIV_BITS = 3,
  parameter int GAP_CYCLES   = 64
) (
  input  logic           clk,
  input  logic           reset,
  frame_sender_if.master bus
);

  localparam int PW   = 3 * CDEPTH;
  localparam int HALF = 1 << SCK_DIV_BITS;
  localparam int HW   = (SCK_DIV_BITS > 0) ? SCK_DIV_BITS : 1;
  localparam int BW   = (PW > 1) ? $clog2(PW) : 1;
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [HW-1:0] HCNT_LAST = HW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PW - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_GAP,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;
  logic [FRAME_ORDER-1:0] addr_q, addr_d;
  // Bit 0 of the pixel goes straight to sdi at LOAD, so only the remaining
  // bits are kept; bit 0 of this register is always the next bit to send.
  logic [PW-2:0]          shreg_q, shreg_d;
  logic                   sck_q, sck_d;
  logic                   sdi_q, sdi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef FRAME_SENDER_CS_EN
  logic                   cs_n_q, cs_n_d;
`endif

  logic                   hcnt_last;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      bitcnt_q <= '0;
      gcnt_q   <= '0;
      addr_q   <= '0;
      shreg_q  <= '0;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FRAME_SENDER_CS_EN
      cs_n_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bitcnt_q <= bitcnt_d;
      gcnt_q   <= gcnt_d;
      addr_q   <= addr_d;
      shreg_q  <= shreg_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FRAME_SENDER_CS_EN
      cs_n_q   <= cs_n_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. Outputs are computed for the state being entered, so sck,
  // sdi, busy, done (and cs_n) are registered yet line up with the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    bitcnt_d = bitcnt_q;
    gcnt_d   = gcnt_q;
    addr_d   = addr_q;
    shreg_d  = shreg_q;
    sck_d    = sck_q;
    sdi_d    = sdi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef FRAME_SENDER_CS_EN
    cs_n_d   = cs_n_q;
`endif

    hcnt_last = (hcnt_q == HCNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          busy_d  = 1'b1;
`ifdef FRAME_SENDER_CS_EN
          cs_n_d  = 1'b0;
`endif
        end
      end

      // pix is only looked at here; buffer writes during the shift-out of a
      // pixel do not disturb it.
      S_LOAD: begin
        shreg_d  = bus.pix[PW-1:1];
        sdi_d    = bus.pix[0];
        bitcnt_d = '0;
        hcnt_d   = '0;
        sck_d    = 1'b0;
        state_d  = S_LOW;
      end

      S_LOW: begin
        if (hcnt_last) begin
          hcnt_d  = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      // sdi only moves on the way out of HIGH, i.e. together with the sck
      // falling edge, never while sck is high.
      S_HIGH: begin
        if (hcnt_last) begin
          hcnt_d = '0;
          sck_d  = 1'b0;
          if (bitcnt_q != BIT_LAST) begin
            bitcnt_d = bitcnt_q + BW'(1);
            sdi_d    = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            state_d  = S_LOW;
          end else if (addr_q != '1) begin
            addr_d  = addr_q + FRAME_ORDER'(1);
            state_d = S_LOAD;
          end else begin
            sdi_d   = 1'b0;
            gcnt_d  = '0;
            state_d = S_GAP;
`ifdef FRAME_SENDER_CS_EN
            cs_n_d  = 1'b1;
`endif
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end

      // start is not sampled here, so a held start leaves one IDLE cycle
      // between frames.
      S_DONE: begin
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.addr = addr_q;
  assign bus.sck  = sck_q;
  assign bus.sdi  = sdi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef FRAME_SENDER_CS_EN
  assign bus.cs_n = cs_n_q;
`endif

endmodule
